// File: rtl/mailbox_fifo.sv
// Strobe-driven mailbox FIFO between the Z80 bus side and the core.
// Pushes and pops act on strobe rising edges only; error flags are sticky until cleared.
module mailbox_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_strobe,
  input  logic                  read_strobe,
  input  logic                  clear_flags,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  ready,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_old_q, rd_old_q;
  logic                  wr_edge, rd_edge;
  logic                  empty, is_full;
  logic                  do_push, do_pop;

  always_comb begin
    wr_edge = write_strobe & ~wr_old_q;
    rd_edge = read_strobe & ~rd_old_q;
    empty   = (count_q == '0);
    is_full = (count_q == CW'(DEPTH));
    do_pop  = rd_edge & ~empty;
    // A pop in the same cycle frees the slot the write pointer sits on when full.
    do_push = wr_edge & (~is_full | do_pop);

    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);

    // A fresh error event beats a same-cycle clear.
    ovf_d = (wr_edge & ~do_push) | (ovf_q & ~clear_flags);
    unf_d = (rd_edge & empty)    | (unf_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      wr_old_q <= 1'b0;
      rd_old_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wr_old_q <= write_strobe;
      rd_old_q <= read_strobe;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign ready     = ~empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_mailbox_fifo.sv
// Bench for mailbox_fifo: a cycle-by-cycle vector table for the single-step behaviour,
// then scoreboard-driven sequences for held strobes, full swap, reset and pointer wrap.
module tb_mailbox_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic       clear_flags = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       ready, full, overflow, underflow;
  logic [2:0] count;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] sb[$];

  mailbox_fifo #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .write_strobe(write_strobe), .read_strobe(read_strobe),
    .clear_flags(clear_flags), .data_in(data_in), .data_out(data_out), .ready(ready),
    .full(full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, wr, rd, clr;
    logic [7:0] din;
    logic [2:0] cnt;
    logic [7:0] dout;
    logic       rdy, ful, ov, un;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic rst, wr, rd, clr, input logic [7:0] din,
                              input logic [2:0] cnt, input logic [7:0] dout,
                              input logic rdy, ful, ov, un);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.cnt = cnt; v.dout = dout; v.rdy = rdy; v.ful = ful; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] d);
    data_in = d;
    write_strobe = 1'b1;
    cycle();
    write_strobe = 1'b0;
    if (sb.size() < 4) sb.push_back(d);
    check("push_count", 32'(count), 32'(sb.size()));
    cycle();
  endtask

  task automatic pop();
    logic [7:0] exp;
    if (sb.size() == 0) begin
      check("pop_sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    exp = sb.pop_front();
    check("pop_head", 32'(data_out), 32'(exp));
    read_strobe = 1'b1;
    cycle();
    read_strobe = 1'b0;
    check("pop_count", 32'(count), 32'(sb.size()));
    cycle();
  endtask

  initial begin
    //            rst wr rd clr din    cnt dout  rdy ful ov un
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 8'hA5, 1, 8'hA5, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 8'h00, 1, 8'hA5, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 8'h11, 1, 8'h11, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 8'h22, 2, 8'h11, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 8'h00, 2, 8'h11, 1, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 8'h33, 3, 8'h11, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 8'h00, 3, 8'h11, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 8'h44, 4, 8'h11, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 8'h00, 4, 8'h11, 1, 1, 0, 0);
    vecs[13] = mk(0, 1, 0, 0, 8'h55, 4, 8'h11, 1, 1, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 8'h00, 4, 8'h11, 1, 1, 1, 0);
    vecs[15] = mk(0, 0, 1, 0, 8'h00, 3, 8'h22, 1, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 8'h00, 3, 8'h22, 1, 0, 1, 0);
    vecs[17] = mk(0, 0, 1, 0, 8'h00, 2, 8'h33, 1, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 0, 8'h00, 2, 8'h33, 1, 0, 1, 0);
    vecs[19] = mk(0, 0, 1, 0, 8'h00, 1, 8'h44, 1, 0, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 8'h00, 1, 8'h44, 1, 0, 1, 0);
    vecs[21] = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    vecs[23] = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1);
    vecs[24] = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[26] = mk(0, 1, 1, 0, 8'h77, 1, 8'h77, 1, 0, 0, 1);
    vecs[27] = mk(0, 0, 0, 1, 8'h00, 1, 8'h77, 1, 0, 0, 0);
    vecs[28] = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    vecs[30] = mk(0, 0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    vecs[31] = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0);

    cycle();
    for (int i = 0; i < 32; i++) begin
      reset = vecs[i].rst;
      write_strobe = vecs[i].wr;
      read_strobe = vecs[i].rd;
      clear_flags = vecs[i].clr;
      data_in = vecs[i].din;
      cycle();
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_data_out", i), 32'(data_out), 32'(vecs[i].dout));
      check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].ful));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
      check($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].un));
    end
    reset = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0; clear_flags = 1'b0;
    cycle();

    // Held write strobe: one push per rising edge.
    data_in = 8'hD0;
    write_strobe = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check("hold_count", 32'(count), 32'd1);
    sb.push_back(8'hD0);
    write_strobe = 1'b0;
    cycle();
    data_in = 8'hD1;
    write_strobe = 1'b1;
    cycle();
    sb.push_back(8'hD1);
    check("rearm_count", 32'(count), 32'd2);
    write_strobe = 1'b0;
    cycle();
    pop();
    pop();

    // Simultaneous edges while full: swap head for new word, no overflow.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("full_flag", 32'(full), 32'd1);
    check("swap_head_before", 32'(data_out), 32'(sb.pop_front()));
    sb.push_back(8'h99);
    data_in = 8'h99;
    write_strobe = 1'b1;
    read_strobe = 1'b1;
    cycle();
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    check("swap_count", 32'(count), 32'd4);
    check("swap_overflow", 32'(overflow), 32'd0);
    check("swap_full", 32'(full), 32'd1);
    cycle();
    pop(); pop(); pop(); pop();
    check("drained_ready", 32'(ready), 32'd0);

    // Reset mid-stream with a write edge in the reset cycle.
    read_strobe = 1'b1;
    cycle();
    read_strobe = 1'b0;
    check("pre_reset_underflow", 32'(underflow), 32'd1);
    cycle();
    push(8'hE1); push(8'hE2); push(8'hE3);
    reset = 1'b1;
    data_in = 8'hC3;
    write_strobe = 1'b1;
    cycle();
    sb.delete();
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    cycle();
    sb.push_back(8'hC3);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_data_out", 32'(data_out), 32'hC3);
    write_strobe = 1'b0;
    cycle();

    // Push/pop pairs walk both pointers past the wrap point.
    for (int i = 0; i < 6; i++) begin
      push(8'h60 + 8'(i));
      pop();
    end
    pop();
    check("final_empty_data", 32'(data_out), 32'd0);
    check("final_flags", 32'({overflow, underflow}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
